// File: rtl/xbar_rr_slave_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_rr_slave_scheduler_pkg: XbarV1 shared state encodings and sel width.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package xbar_rr_slave_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int MUXSEL_NONE = 0;

    // Shared with SlaveMux/MasterMux so every select bus agrees on width.
    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_rr_slave_scheduler_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_rr_pick: combinational rotate-priority encoder starting after ptr.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module xbar_rr_pick
    import xbar_rr_slave_scheduler_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    input  logic [NUM-1:0] excl_i,
    output logic           valid_o,
    output logic [IW-1:0]  idx_o
);

    logic [IW-1:0] cand;

    // Walk candidates ptr+1, ptr+2, ... wrapping at NUM; the first eligible wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = ptr_i;
        for (int i = 0; i < NUM; i++) begin
            cand = (cand == IW'(NUM - 1)) ? '0 : cand + IW'(1);
            if (!valid_o && req_i[cand] && !excl_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbar_rr_slave_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_rr_slave_scheduler: per-slave round-robin grant FSM with lock/watchdog|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module xbar_rr_slave_scheduler
    import xbar_rr_slave_scheduler_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_LOCK_CYCLES = 64,
    parameter int SEL_W           = sel_width(NUM_MASTERS)
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [NUM_MASTERS-1:0] i_Req,
    input  logic [NUM_MASTERS-1:0] i_Lock,
    input  logic                   i_Ack,
    output logic [NUM_MASTERS-1:0] o_Gnt,
    output logic [SEL_W-1:0]       o_MuxSel,
    output logic                   o_Busy,
    output logic                   o_LockTimeout
);

    localparam int IW    = $clog2(NUM_MASTERS);
    localparam int CNT_W = (MAX_LOCK_CYCLES < 1) ? 1 : $clog2(MAX_LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK_CYCLES);

    state_e                 state_q;
    logic [IW-1:0]          ptr_q;
    logic [IW-1:0]          gidx_q;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [SEL_W-1:0]       muxsel_q;
    logic                   busy_q;
    logic                   lock_to_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   locked_q;

    logic                   w_expired;
    logic                   w_arb;
    logic                   w_to_hold;
    logic                   w_rebusy;
    logic                   w_timeout;
    logic [NUM_MASTERS-1:0] w_excl;
    logic                   w_pick_valid;
    logic [IW-1:0]          w_pick_idx;

    assign w_expired = (cnt_q >= LOCK_MAX);
    // Only a watchdog break out of HOLD keeps the current owner out of the pick.
    assign w_excl    = (state_q == ST_HOLD && w_timeout) ? gnt_q : '0;

    xbar_rr_pick #(
        .NUM (NUM_MASTERS),
        .IW  (IW)
    ) u_pick (
        .req_i   (i_Req),
        .ptr_i   (ptr_q),
        .excl_i  (w_excl),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    always_comb begin
        w_arb     = 1'b0;
        w_to_hold = 1'b0;
        w_rebusy  = 1'b0;
        w_timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: w_arb = 1'b1;
            ST_BUSY: begin
                if (i_Ack) begin
                    if (i_Lock[gidx_q] && !w_expired) begin
                        w_to_hold = 1'b1;
                    end else begin
                        w_arb     = 1'b1;
                        w_timeout = i_Lock[gidx_q];
                    end
                end
            end
            ST_HOLD: begin
                if (i_Req[gidx_q]) begin
                    w_rebusy = 1'b1;
                end else if (!i_Lock[gidx_q]) begin
                    w_arb = 1'b1;
                end else if (w_expired) begin
                    w_arb     = 1'b1;
                    w_timeout = 1'b1;
                end
            end
            default: w_arb = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(NUM_MASTERS - 1);
            gidx_q    <= '0;
            gnt_q     <= '0;
            muxsel_q  <= SEL_W'(MUXSEL_NONE);
            busy_q    <= 1'b0;
            lock_to_q <= 1'b0;
            cnt_q     <= '0;
            locked_q  <= 1'b0;
        end else begin
            lock_to_q <= w_timeout;
            if (w_arb) begin
                cnt_q    <= '0;
                locked_q <= 1'b0;
                if (w_pick_valid) begin
                    state_q  <= ST_BUSY;
                    ptr_q    <= w_pick_idx;
                    gidx_q   <= w_pick_idx;
                    gnt_q    <= NUM_MASTERS'(1) << w_pick_idx;
                    muxsel_q <= SEL_W'(w_pick_idx) + SEL_W'(1);
                    busy_q   <= 1'b1;
                end else begin
                    state_q  <= ST_IDLE;
                    gnt_q    <= '0;
                    muxsel_q <= SEL_W'(MUXSEL_NONE);
                    busy_q   <= 1'b0;
                end
            end else begin
                // Watchdog age runs from the first locked ack and saturates.
                if (locked_q && cnt_q < LOCK_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (w_to_hold) begin
                    state_q  <= ST_HOLD;
                    busy_q   <= 1'b0;
                    locked_q <= 1'b1;
                end else if (w_rebusy) begin
                    state_q <= ST_BUSY;
                    busy_q  <= 1'b1;
                end
            end
        end
    end

    assign o_Gnt         = gnt_q;
    assign o_MuxSel      = muxsel_q;
    assign o_Busy        = busy_q;
    assign o_LockTimeout = lock_to_q;

endmodule
`default_nettype wire

// File: tb/tb_xbar_rr_slave_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xbar_rr_slave_scheduler: directed + random stimulus vs reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_xbar_rr_slave_scheduler;

    localparam int N     = 4;
    localparam int MAXL  = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             r_rst_n = 1'b0;
    logic [N-1:0]     r_req = '0;
    logic [N-1:0]     r_lock = '0;
    logic             r_ack = 1'b0;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_muxsel;
    logic             w_busy;
    logic             w_lock_to;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: owner index (-1 none), busy flag, last winner,
    // cycles since the first locked ack of the current tenure (-1 = none yet).
    int m_owner;
    bit m_busy;
    int m_last;
    int m_age;
    bit m_to;
    bit m_ok = 1'b0;

    always #5 clk = ~clk;

    xbar_rr_slave_scheduler #(
        .NUM_MASTERS     (N),
        .MAX_LOCK_CYCLES (MAXL)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (r_rst_n),
        .i_Req         (r_req),
        .i_Lock        (r_lock),
        .i_Ack         (r_ack),
        .o_Gnt         (w_gnt),
        .o_MuxSel      (w_muxsel),
        .o_Busy        (w_busy),
        .o_LockTimeout (w_lock_to)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last, input int excl);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_arb(input logic [N-1:0] req, input int excl);
        int w;
        w = rr_pick(req, m_last, excl);
        if (w >= 0) begin
            m_owner = w;
            m_busy  = 1'b1;
            m_last  = w;
        end else begin
            m_owner = -1;
            m_busy  = 1'b0;
        end
        m_age = -1;
    endtask

    task automatic model_step(input bit rst_n, input logic [N-1:0] req,
                              input logic [N-1:0] lock, input bit ack);
        int cnt;
        bit expired;
        m_to = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_busy  = 1'b0;
            m_last  = N - 1;
            m_age   = -1;
            m_ok    = 1'b1;
            return;
        end
        cnt     = (m_age < 0) ? 0 : ((m_age > MAXL) ? MAXL : m_age);
        expired = (cnt >= MAXL);
        if (m_owner < 0) begin
            model_arb(req, -1);
        end else if (m_busy) begin
            if (ack) begin
                if (lock[m_owner] && !expired) begin
                    m_busy = 1'b0;
                    m_age  = (m_age < 0) ? 0 : m_age + 1;
                end else begin
                    m_to = lock[m_owner];
                    model_arb(req, -1);
                end
            end else if (m_age >= 0) begin
                m_age++;
            end
        end else begin
            if (req[m_owner]) begin
                m_busy = 1'b1;
                m_age++;
            end else if (!lock[m_owner]) begin
                model_arb(req, -1);
            end else if (expired) begin
                m_to = 1'b1;
                model_arb(req, m_owner);
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]     e_gnt;
        logic [SEL_W-1:0] e_sel;
        if (!m_ok) return;
        e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e_sel = SEL_W'(m_owner + 1);
        check_eq("gnt", 32'(w_gnt), 32'(e_gnt));
        check_eq("muxsel", 32'(w_muxsel), 32'(e_sel));
        check_eq("busy", 32'(w_busy), 32'(m_busy));
        check_eq("lock_timeout", 32'(w_lock_to), 32'(m_to));
    endtask

    task automatic step(input bit rst_n, input logic [N-1:0] req,
                        input logic [N-1:0] lock, input bit ack);
        @(negedge clk);
        check_outputs();
        r_rst_n = rst_n;
        r_req   = req;
        r_lock  = lock;
        r_ack   = ack;
        model_step(rst_n, req, lock, ack);
    endtask

    initial begin
        // Reset with everybody requesting, then round-robin with ack every 3rd cycle.
        repeat (3) step(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 4'b1111, 4'b0000, (i % 3) == 2);

        // Lock hold by master 2 across three transactions, then lock drop.
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0100, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 4'b0111, 4'b0100, (i % 4) == 1);
        step(1'b1, 4'b0011, 4'b0100, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1011, 4'b0000, i == 1);

        // Watchdog: master 1 locks continuously against master 0.
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 4'b0011, 4'b0010, (i % 2) == 1);

        // Request withdrawal mid-BUSY, ack while idle, sole requester back-to-back.
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 4'b0001, 4'b0000, (i % 2) == 1);

        // Reset while master 2 is mid-transaction.
        step(1'b0, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0);
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0, N'($urandom),
                 N'($urandom & $urandom), $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        check_outputs();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
